if_stage: RTL and testbench

//   Instruction-fetch stage of the 5-stage RV32I pipeline: owns the PC, issues one

---
 rtl/if_stage_pkg.sv | 6 +
 rtl/if_stage.sv | 71 +++++++
 tb/tb_if_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared pipeline constants and fetch FSM state type.
package if_stage_pkg;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;
    typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} fetch_state_t;
endpackage

// File: rtl/if_stage.sv
// if_stage: RV32I fetch stage owning the PC, one outstanding imem request, a stall
// hold buffer, EXE redirects and the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazardStall,
    input  logic        AXI_MEM_stall,
    input  logic        EXE_jumpBranch,
    input  logic [31:0] EXE_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_reg,
    output logic [31:0] pc_reg,
    output logic        fetch_stall
);
    fetch_state_t state, state_nxt;
    logic [31:0]  pc, hold_buf, instr;
    logic         redir_lock, have_instr, adv, redir;

    always_comb begin
        have_instr = (state == WAIT && imem_rvalid) || state == HOLD;
        instr      = state == HOLD ? hold_buf : imem_rdata;
        adv        = have_instr && !AXI_MEM_stall && !hazardStall;
        redir      = EXE_jumpBranch && !redir_lock;
        state_nxt  = state;
        case (state)
            ISSUE:   state_nxt = redir ? DROP : WAIT;
            WAIT:    state_nxt = imem_rvalid ? ((adv || redir) ? ISSUE : HOLD) : (redir ? DROP : WAIT);
            HOLD:    state_nxt = (adv || redir) ? ISSUE : HOLD;
            DROP:    state_nxt = imem_rvalid ? ISSUE : DROP;
            default: state_nxt = ISSUE;
        endcase
    end

    assign fetch_stall = !have_instr;
    assign imem_req    = state == ISSUE && !rst;
    assign imem_addr   = pc;

    // The lock keeps a held EXE_jumpBranch from re-squashing the target fetch while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ISSUE;
            pc              <= RESET_PC;
            hold_buf        <= '0;
            redir_lock      <= 1'b0;
            instruction_reg <= NOP_INST;
            pc_reg          <= '0;
        end else begin
            state      <= state_nxt;
            redir_lock <= AXI_MEM_stall && (redir_lock || redir);
            if (state == WAIT && imem_rvalid && !adv && !redir)
                hold_buf <= imem_rdata;
            if (redir) begin
                pc              <= {EXE_target[31:2], 2'b00};
                instruction_reg <= NOP_INST;
                pc_reg          <= '0;
            end else if (adv) begin
                instruction_reg <= instr;
                pc_reg          <= pc;
                pc              <= pc + 32'd4;
            end
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized bench checking if_stage against a transaction-level fetch model.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazardStall = 1'b0, AXI_MEM_stall = 1'b0, EXE_jumpBranch = 1'b0;
    logic [31:0] EXE_target = '0;
    logic        imem_req, imem_rvalid = 1'b0, fetch_stall;
    logic [31:0] imem_addr, imem_rdata = '0, instruction_reg, pc_reg;

    int n_checks = 0, n_errors = 0;

    // model: next fetch pc, IF/ID contents, buffered word, outstanding request
    logic [31:0] m_pc = '0, m_ir = NOP, m_pcr = '0, m_aw = '0;
    bit          m_avail = 0, m_out = 0, m_squash = 0, m_lock = 0;

    // memory: single outstanding read, latency 1 + mem_cnt cycles
    bit          mem_busy = 0;
    int          mem_cnt = 0, mem_lat = 0;
    logic [31:0] mem_addr = '0;

    if_stage dut (
        .clk(clk), .rst(rst), .hazardStall(hazardStall), .AXI_MEM_stall(AXI_MEM_stall),
        .EXE_jumpBranch(EXE_jumpBranch), .EXE_target(EXE_target), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instruction_reg(instruction_reg), .pc_reg(pc_reg), .fetch_stall(fetch_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC3C3_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_ir = NOP; m_pcr = '0; m_aw = '0;
        m_avail = 0; m_out = 0; m_squash = 0; m_lock = 0;
        mem_busy = 0; mem_cnt = 0;
    endtask

    // one clock cycle: drive at posedge+1, check and advance the model at negedge
    task automatic step(input bit h, input bit s, input bit j, input logic [31:0] t);
        bit exp_req, arrive, good, have, redir;
        logic [31:0] word;
        hazardStall = h; AXI_MEM_stall = s; EXE_jumpBranch = j; EXE_target = t;
        imem_rvalid = mem_busy && mem_cnt == 0;
        imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;
        @(negedge clk);
        exp_req = !m_out && !m_avail;
        check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) check("imem_addr", imem_addr, m_pc);
        arrive = m_out && imem_rvalid;
        good   = arrive && !m_squash;
        have   = m_avail || good;
        check("fetch_stall", {31'b0, fetch_stall}, {31'b0, !have});
        check("instruction_reg", instruction_reg, m_ir);
        check("pc_reg", pc_reg, m_pcr);
        word  = m_avail ? m_aw : imem_rdata;
        redir = j && !m_lock;
        if (arrive) m_out = 0;
        if (exp_req) begin m_out = 1; m_squash = 0; end
        if (redir) begin
            m_pc = t & ~32'd3; m_ir = NOP; m_pcr = '0; m_avail = 0;
            if (m_out) m_squash = 1;
        end else if (have && !s && !h) begin
            m_ir = word; m_pcr = m_pc; m_pc = m_pc + 32'd4; m_avail = 0;
        end else if (have) begin
            m_avail = 1; m_aw = word;
        end
        m_lock = s && (m_lock || redir);
        if (imem_rvalid) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (imem_req) begin
            mem_busy = 1; mem_addr = imem_addr;
            mem_cnt = mem_lat < 0 ? int'($urandom_range(0, 2)) : mem_lat;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ir", instruction_reg, NOP);
        check("rst_pc_reg", pc_reg, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_fetch_stall", {31'b0, fetch_stall}, 32'h1);
        rst = 1'b0;
        // sequential fetch with 1-cycle memory
        mem_lat = 0;
        repeat (8) step(0, 0, 0, 0);
        // load-use stall holding a returned word
        step(0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        // redirect while waiting on a slow response
        mem_lat = 3;
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h100);
        repeat (8) step(0, 0, 0, 0);
        // redirect held across a memory stall
        mem_lat = 0;
        repeat (5) step(0, 1, 1, 32'h200);
        repeat (6) step(0, 0, 0, 0);
        // pc wrap at the top of the address space, misaligned target
        step(0, 0, 1, 32'hFFFF_FFFF);
        repeat (8) step(0, 0, 0, 0);
        // asynchronous reset in the middle of a request
        mem_lat = 3;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check("async_ir", instruction_reg, NOP);
        check("async_pc_reg", pc_reg, 32'h0);
        check("async_req", {31'b0, imem_req}, 32'h0);
        check("async_fetch_stall", {31'b0, fetch_stall}, 32'h1);
        model_reset();
        imem_rvalid = 1'b0; hazardStall = 0; AXI_MEM_stall = 0; EXE_jumpBranch = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        // randomized traffic
        mem_lat = -1;
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 7) == 0 ? 32'hFFFF_FFFC : $urandom);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
